cp0_exc_ctrl: RTL

- Exception/interrupt sequencer for the CP0 register file (Status, Cause, EPC; each a plain W/D/Q register).
- Arbitrates every write into those registers between exception entry, ERET, MTC0 and the hardware-interrupt IP refresh.
- Sequences exception entry and return, and drives the PC redirect and pipeline stall.
- Sits between the execute/writeback stage and the CP0 registers.

---
 rtl/cp0_pkg.sv | 34 +++
 rtl/cp0_exc_prio.sv | 35 +++
 rtl/cp0_exc_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared types and constants for the CP0 exception sequencer.
// Bit positions refer to the MIPS Status and Cause register layouts.
package cp0_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSave,
        StMask,
        StRestore,
        StRedirect
    } cp0_state_e;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int unsigned IE_BIT      = 0;
    localparam int unsigned EXL_BIT     = 1;
    localparam int unsigned IP_LSB      = 10;
    localparam int unsigned IP_MSB      = 15;
    localparam int unsigned SW_IP_LSB   = 8;
    localparam int unsigned SW_IP_MSB   = 9;
    localparam int unsigned EXCCODE_LSB = 2;
    localparam int unsigned EXCCODE_MSB = 6;

    localparam logic [31:0] EXL_MASK = 32'h1 << EXL_BIT;

    localparam logic [1:0] SEL_STATUS = 2'd0;
    localparam logic [1:0] SEL_CAUSE  = 2'd1;
    localparam logic [1:0] SEL_EPC    = 2'd2;
    localparam logic [1:0] SEL_NONE   = 2'd3;

endpackage

// File: rtl/cp0_exc_prio.sv
// Combinational priority encoder: ov > ri > sys > masked hardware interrupt.
// Synchronous exceptions ignore IE; interrupts need IE=1, EXL=0 and an unmasked line.
module cp0_exc_prio
    import cp0_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 6
) (
    input  logic [2:0]         exc_valid,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               ie,
    input  logic               exl,
    input  logic [NUM_IRQ-1:0] im,
    output logic               take,
    output logic [4:0]         code
);

    logic irq_hit;

    assign irq_hit = ie && !exl && ((irq & im) != '0);

    always_comb begin
        take = 1'b1;
        code = EXC_INT;
        if (exc_valid[2]) begin
            code = EXC_OV;
        end else if (exc_valid[1]) begin
            code = EXC_RI;
        end else if (exc_valid[0]) begin
            code = EXC_SYS;
        end else if (!irq_hit) begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates Status/Cause/EPC writes between
// exception entry, ERET, MTC0 and the hardware IP refresh, and drives redirect/stall.
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_4180,
    parameter int unsigned NUM_IRQ     = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         exc_valid,
    input  logic [31:0]        exc_pc,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               eret,
    input  logic               mtc0_req,
    input  logic [1:0]         mtc0_sel,
    input  logic [31:0]        mtc0_data,
    output logic               mtc0_ack,
    input  logic [31:0]        status_q,
    input  logic [31:0]        cause_q,
    input  logic [31:0]        epc_q,
    output logic               status_we,
    output logic               cause_we,
    output logic               epc_we,
    output logic [31:0]        status_d,
    output logic [31:0]        cause_d,
    output logic [31:0]        epc_d,
    output logic               busy,
    output logic               pc_redirect,
    output logic [31:0]        redirect_pc
);

    cp0_state_e  state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;

    logic        take;
    logic [4:0]  take_code;
    logic        idle;
    logic        ev_exc;
    logic        ev_eret;
    logic        mtc0_ok;
    logic [31:0] cause_ip;

    cp0_exc_prio #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .exc_valid (exc_valid),
        .irq       (irq),
        .ie        (status_q[IE_BIT]),
        .exl       (status_q[EXL_BIT]),
        .im        (status_q[IP_LSB +: NUM_IRQ]),
        .take      (take),
        .code      (take_code)
    );

    // Gated by rst_n so nothing combinational leaks out while reset is held.
    assign idle    = (state_q == StIdle) && rst_n;
    assign ev_exc  = idle && take;
    assign ev_eret = idle && !take && eret;
    assign mtc0_ok = idle && !take && !eret && mtc0_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            code_q   <= '0;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        pc_d        = pc_q;
        target_d    = target_q;
        mtc0_ack    = 1'b0;
        status_we   = 1'b0;
        cause_we    = 1'b0;
        epc_we      = 1'b0;
        status_d    = '0;
        cause_d     = '0;
        epc_d       = '0;
        pc_redirect = 1'b0;
        redirect_pc = '0;
        busy        = (state_q != StIdle) || ev_exc || ev_eret;

        cause_ip = cause_q;
        cause_ip[IP_LSB +: NUM_IRQ] = irq;

        case (state_q)
            StIdle: begin
                if (ev_exc) begin
                    code_d  = take_code;
                    pc_d    = exc_pc;
                    state_d = StSave;
                end else if (ev_eret) begin
                    state_d = StRestore;
                end else begin
                    if (mtc0_ok) begin
                        mtc0_ack = 1'b1;
                        unique case (mtc0_sel)
                            SEL_STATUS: begin
                                status_we = 1'b1;
                                status_d  = mtc0_data;
                            end
                            SEL_CAUSE: begin
                                cause_we = 1'b1;
                                cause_d  = cause_ip;
                                cause_d[SW_IP_MSB:SW_IP_LSB] = mtc0_data[SW_IP_MSB:SW_IP_LSB];
                            end
                            SEL_EPC: begin
                                epc_we = 1'b1;
                                epc_d  = mtc0_data;
                            end
                            SEL_NONE: ;
                        endcase
                    end
                    // IP refresh yields to an MTC0 Cause write, which carries irq anyway.
                    if (idle && !cause_we && (cause_q[IP_LSB +: NUM_IRQ] != irq)) begin
                        cause_we = 1'b1;
                        cause_d  = cause_ip;
                    end
                end
            end
            StSave: begin
                cause_we = 1'b1;
                cause_d  = cause_ip;
                cause_d[EXCCODE_MSB:EXCCODE_LSB] = code_q;
                // A nested exception under EXL keeps the original return address.
                if (!status_q[EXL_BIT]) begin
                    epc_we = 1'b1;
                    epc_d  = pc_q;
                end
                state_d = StMask;
            end
            StMask: begin
                status_we = 1'b1;
                status_d  = status_q | EXL_MASK;
                target_d  = HANDLER_VEC;
                state_d   = StRedirect;
            end
            StRestore: begin
                status_we = 1'b1;
                status_d  = status_q & ~EXL_MASK;
                target_d  = epc_q;
                state_d   = StRedirect;
            end
            StRedirect: begin
                pc_redirect = 1'b1;
                redirect_pc = target_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule
